// File: rtl/ttfir_serial.sv
// Purpose: coefficient-programmable FIR filter, one shared multiply-accumulate stepped over N_TAPS taps per sample.
// Latency: y_valid pulses in the cycle after the N_TAPS-th rising edge following acceptance; one sample per N_TAPS+1 cycles.
// Backpressure: x_ready is low while a MAC pass runs or while coef_load is high; y_out has no downstream stall.
module ttfir_serial #(
  parameter int N_TAPS  = 4,
  parameter int BW_in   = 6,
  parameter int BW_coef = 6,
  parameter int BW_out  = 8,
  parameter int SHIFT   = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic signed [BW_in-1:0]   x_in,
  input  logic                      x_valid,
  output logic                      x_ready,
  input  logic signed [BW_coef-1:0] coef_in,
  input  logic                      coef_load,
  output logic signed [BW_out-1:0]  y_out,
  output logic                      y_valid
);

  localparam int KW   = $clog2(N_TAPS);
  localparam int PW   = BW_in + BW_coef;
  localparam int ACCW = PW + $clog2(N_TAPS);
  // One guard bit so the rounding offset cannot wrap the full-scale sum.
  localparam int EW   = ACCW + 1;
  localparam logic [KW-1:0] KLAST = KW'(N_TAPS - 1);
  localparam logic signed [EW-1:0] YMAX = {{(EW-BW_out+1){1'b0}}, {(BW_out-1){1'b1}}};
  localparam logic signed [EW-1:0] YMIN = ~YMAX;

  typedef enum logic {IDLE, MAC} state_t;

  state_t state, state_nxt;

  logic signed [BW_in-1:0]   x [N_TAPS];
  logic signed [BW_coef-1:0] c [N_TAPS];
  logic signed [ACCW-1:0]    acc;
  logic [KW-1:0]             k;

  logic                      accept;
  logic                      load;
  logic                      last;
  logic signed [PW-1:0]      prod;
  logic signed [ACCW-1:0]    sum;
  logic signed [EW-1:0]      sum_ext;
  logic signed [EW-1:0]      rnd_val;
  logic signed [BW_out-1:0]  sat_y;

  // State register; reset drops any in-flight MAC pass back to IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state and handshake: coefficient loading wins over sample acceptance.
  always_comb begin
    state_nxt = state;
    x_ready   = 1'b0;
    accept    = 1'b0;
    load      = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        x_ready = !coef_load;
        if (coef_load) begin
          load = 1'b1;
        end else if (x_valid) begin
          accept    = 1'b1;
          state_nxt = MAC;
        end
      end
      MAC: begin
        if (k == KLAST) begin
          last      = 1'b1;
          state_nxt = IDLE;
        end
      end
    endcase
  end

  // Current tap product and running sum; the final tap's product is included in the output.
  always_comb begin
    prod    = PW'(x[k]) * PW'(c[k]);
    sum     = acc + ACCW'(prod);
    sum_ext = EW'(sum);
  end

  // Round half-up then arithmetic shift; a zero shift passes the sum through untouched.
  if (SHIFT > 0) begin : g_rnd
    localparam logic signed [EW-1:0] HALF = EW'(1) << (SHIFT - 1);
    assign rnd_val = (sum_ext + HALF) >>> SHIFT;
  end else begin : g_nornd
    assign rnd_val = sum_ext;
  end

  // Clamp the rounded value into the signed output range.
  always_comb begin
    if (rnd_val > YMAX)      sat_y = {1'b0, {(BW_out-1){1'b1}}};
    else if (rnd_val < YMIN) sat_y = {1'b1, {(BW_out-1){1'b0}}};
    else                     sat_y = rnd_val[BW_out-1:0];
  end

  // Coefficient chain; comes out of reset as an identity filter (c[0]=1).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_TAPS; i++) c[i] <= '0;
      c[0] <= BW_coef'(1);
    end else if (load) begin
      for (int i = N_TAPS - 1; i > 0; i--) c[i] <= c[i-1];
      c[0] <= coef_in;
    end
  end

  // Delay line moves only when a sample is accepted, never during a MAC pass.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_TAPS; i++) x[i] <= '0;
    end else if (accept) begin
      for (int i = N_TAPS - 1; i > 0; i--) x[i] <= x[i-1];
      x[0] <= x_in;
    end
  end

  // Accumulator and tap index; the index wraps to 0 on the last tap so it never leaves range.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
      k   <= '0;
    end else if (accept) begin
      acc <= '0;
      k   <= '0;
    end else if (state == MAC) begin
      acc <= sum;
      k   <= last ? '0 : k + KW'(1);
    end
  end

  // Output register: y_out holds between passes, y_valid is a single-cycle strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      y_out   <= '0;
      y_valid <= 1'b0;
    end else begin
      y_valid <= last;
      if (last) y_out <= sat_y;
    end
  end

endmodule
